// File: rtl/quad_encoder_tx.sv
// Quadrature transmitter: turns signed step requests into Gray-coded A/B edges
// separated by a fixed dwell, so a downstream debounce + decoder accepts them.
module quad_encoder_tx #(
   parameter int unsigned DWELL = 64,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_valid,
   input  logic             step_dir,
   output logic             step_ready,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic [CNT_W-1:0] pending
);

   localparam int unsigned TMR_W = 16;

   localparam logic [CNT_W-1:0] POS_MAX      = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] NEG_MAX      = ~POS_MAX + CNT_W'(1);
   localparam logic [CNT_W-1:0] PLUS_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MINUS_ONE    = {CNT_W{1'b1}};
   localparam logic [TMR_W-1:0] DWELL_RELOAD = TMR_W'(DWELL - 1);

   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_next;
   logic [CNT_W-1:0] pending_next;
   logic [CNT_W-1:0] emit_delta;
   logic [CNT_W-1:0] accept_delta;
   logic             a_next;
   logic             b_next;
   logic             busy_next;
   logic             emit;
   logic             accept;

   // Refuse only the request that would push the backlog past +/-MAX.
   assign step_ready = !((step_dir && (pending == POS_MAX)) ||
                         (!step_dir && (pending == NEG_MAX)));

   // Next-state: dwell timer, Gray phase step, and pending accumulator.
   always_comb begin
      accept       = 1'b0;
      emit         = 1'b0;
      emit_delta   = '0;
      accept_delta = '0;
      a_next       = a;
      b_next       = b;
      timer_next   = timer;
      pending_next = pending;
      busy_next    = 1'b0;

      accept = step_valid && step_ready;
      emit   = (timer == '0) && (pending != '0);

      if (timer != '0) begin
         timer_next = timer - TMR_W'(1);
      end

      // The phase is {a,b} itself, so exactly one channel toggles per step.
      if (emit) begin
         timer_next = DWELL_RELOAD;
         if (!pending[CNT_W-1]) begin
            a_next     = ~b;
            b_next     = a;
            emit_delta = MINUS_ONE;
         end else begin
            a_next     = b;
            b_next     = ~a;
            emit_delta = PLUS_ONE;
         end
      end

      if (accept) begin
         accept_delta = step_dir ? PLUS_ONE : MINUS_ONE;
      end

      pending_next = pending + emit_delta + accept_delta;
      busy_next    = (pending_next != '0) || (timer_next != '0);
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a       <= 1'b0;
         b       <= 1'b0;
         timer   <= '0;
         pending <= '0;
         busy    <= 1'b0;
      end else begin
         a       <= a_next;
         b       <= b_next;
         timer   <= timer_next;
         pending <= pending_next;
         busy    <= busy_next;
      end
   end

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Self-checking bench for quad_encoder_tx: a scoreboard of expected A/B edges
// is filled as steps are requested and drained by an edge monitor.
module tb_quad_encoder_tx;

   localparam int DWELL = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             step_valid;
   logic             step_dir;
   logic             step_ready;
   logic             a;
   logic             b;
   logic             busy;
   logic [CNT_W-1:0] pending;

   quad_encoder_tx #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .step_valid (step_valid),
      .step_dir   (step_dir),
      .step_ready (step_ready),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [1:0] sb[$];
   int         edge_cyc[$];
   logic [1:0] last_ab = 2'b00;
   int         last_edge = 0;
   bit         have_last = 1'b0;

   // Receiver model: 16-sample stability filter followed by a Gray decoder.
   logic [1:0] cand = 2'b00;
   logic [1:0] filt = 2'b00;
   int         stable = 0;
   int         pos_ev = 0;
   int         neg_ev = 0;

   logic [1:0] cur;
   int         busy_cnt;
   int         peak;
   bit         ok;

   function automatic logic [1:0] gray_step(input logic [1:0] ab, input logic dir);
      case ({dir, ab})
         3'b1_00: return 2'b10;
         3'b1_10: return 2'b11;
         3'b1_11: return 2'b01;
         3'b1_01: return 2'b00;
         3'b0_00: return 2'b01;
         3'b0_01: return 2'b11;
         3'b0_11: return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Edge monitor: every A/B change must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         last_ab   <= 2'b00;
         have_last <= 1'b0;
      end else if ({a, b} !== last_ab) begin
         if (sb.size() == 0) chk("unexpected_edge", 32'({a, b}), 32'(last_ab));
         else chk("edge_ab", 32'({a, b}), 32'(sb.pop_front()));
         if (have_last) chk("edge_gap_min", 32'((cyc - last_edge) >= DWELL), 32'(1));
         edge_cyc.push_back(cyc);
         last_edge <= cyc;
         have_last <= 1'b1;
         last_ab   <= {a, b};
      end
   end

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         cand <= 2'b00; filt <= 2'b00; stable <= 0; pos_ev <= 0; neg_ev <= 0;
      end else if ({a, b} !== cand) begin
         cand   <= {a, b};
         stable <= 1;
      end else begin
         if (stable < 16) stable <= stable + 1;
         if (stable == 15 && cand !== filt) begin
            if (cand == gray_step(filt, 1'b1)) pos_ev <= pos_ev + 1;
            else if (cand == gray_step(filt, 1'b0)) neg_ev <= neg_ev + 1;
            filt <= cand;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("reset_state", 32'({a, b, busy, pending, step_ready}), 32'(8'b0000_0001));
      sb.delete();
      edge_cyc.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      tick();
   endtask

   task automatic send(input logic dir);
      bit acc = 1'b0;
      step_valid = 1'b1;
      step_dir   = dir;
      for (int i = 0; i < 2000 && !acc; i++) begin
         #1;
         if (step_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      step_valid = 1'b0;
      chk("send_accept", 32'(acc), 32'(1));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && (busy || sb.size() != 0); i++) tick();
      chk(tag, 32'({busy, sb.size() == 0}), 32'(2'b01));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      step_valid = 1'b0;
      step_dir = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_held", 32'({a, b, busy, pending, step_ready}), 32'(8'b0000_0001));
      @(negedge clk) reset = 1'b0;

      // Idle after reset release.
      for (int i = 0; i < 200; i++) begin
         tick();
         chk("idle_state", 32'({a, b, busy, pending, step_ready}), 32'(8'b0000_0001));
      end

      // Single positive step: 1-cycle latency, 64-cycle busy window.
      do_reset();
      repeat (10) tick();
      sb.push_back(2'b10);
      send(1'b1);
      chk("t2_pend_acc", 32'(pending), 32'(1));
      busy_cnt = int'(busy);
      tick();
      chk("t2_ab", 32'({a, b}), 32'(2'b10));
      chk("t2_pend_emit", 32'(pending), 32'(0));
      busy_cnt += int'(busy);
      for (int i = 0; i < 300 && busy; i++) begin
         tick();
         busy_cnt += int'(busy);
      end
      chk("t2_busy_len", 32'(busy_cnt), 32'(DWELL));
      repeat (150) tick();
      chk("t2_edge_count", 32'(edge_cyc.size()), 32'(1));

      // Five positive steps back to back.
      do_reset();
      cur = 2'b00;
      for (int i = 0; i < 5; i++) begin
         cur = gray_step(cur, 1'b1);
         sb.push_back(cur);
      end
      peak = 0;
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         if (int'($signed(pending)) > peak) peak = int'($signed(pending));
      end
      for (int i = 0; i < 600 && sb.size() != 0; i++) begin
         tick();
         if (int'($signed(pending)) > peak) peak = int'($signed(pending));
      end
      chk("t3_drained", 32'(sb.size()), 32'(0));
      chk("t3_pend_zero", 32'(pending), 32'(0));
      chk("t3_peak", 32'(peak), 32'(4));
      chk("t3_edge_count", 32'(edge_cyc.size()), 32'(5));
      if (edge_cyc.size() == 5)
         for (int i = 1; i < 5; i++) chk("t3_gap", 32'(edge_cyc[i] - edge_cyc[i-1]), 32'(DWELL));
      wait_idle("t3_idle", 200);

      // Saturation at -7 with step_valid held low-direction.
      do_reset();
      cur = 2'b00;
      for (int i = 0; i < 8; i++) begin
         cur = gray_step(cur, 1'b0);
         sb.push_back(cur);
      end
      step_valid = 1'b1;
      step_dir   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #1 chk("t4_ready", 32'(step_ready), 32'(k < 8));
         @(posedge clk);
         #1;
      end
      step_valid = 1'b0;
      chk("t4_pend_sat", 32'(pending), 32'(4'h9));
      #1 chk("t4_ready_neg", 32'(step_ready), 32'(0));
      step_dir = 1'b1;
      #1 chk("t4_ready_pos", 32'(step_ready), 32'(1));
      step_dir = 1'b0;
      #1;
      for (int i = 0; i < 200 && !step_ready; i++) tick();
      chk("t4_ready_back", 32'(step_ready), 32'(1));
      chk("t4_pend_after", 32'(pending), 32'(4'hA));
      wait_idle("t4_idle", 900);
      chk("t4_edge_count", 32'(edge_cyc.size()), 32'(8));

      // Reversal: cancelled steps produce no edge; crossing zero emits after dwell.
      do_reset();
      sb.push_back(2'b01);
      sb.push_back(2'b00);
      begin
         logic       dirs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         logic [3:0] ep   [6] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'h0, 4'h1};
         for (int i = 0; i < 6; i++) begin
            send(dirs[i]);
            chk("t5_pend", 32'(pending), 32'(ep[i]));
         end
      end
      wait_idle("t5_idle", 300);
      chk("t5_edge_count", 32'(edge_cyc.size()), 32'(2));
      if (edge_cyc.size() == 2) chk("t5_gap", 32'(edge_cyc[1] - edge_cyc[0]), 32'(DWELL));

      // Loopback into the receiver model, then reset mid-burst.
      do_reset();
      cur = 2'b00;
      for (int i = 0; i < 10; i++) begin
         cur = gray_step(cur, 1'b1);
         sb.push_back(cur);
         send(1'b1);
      end
      wait_idle("t6_idle_pos", 1000);
      repeat (30) tick();
      chk("t6_pos_events", 32'(pos_ev), 32'(10));
      chk("t6_neg_events0", 32'(neg_ev), 32'(0));
      for (int i = 0; i < 4; i++) begin
         cur = gray_step(cur, 1'b0);
         sb.push_back(cur);
         send(1'b0);
      end
      wait_idle("t6_idle_neg", 500);
      repeat (30) tick();
      chk("t6_neg_events", 32'(neg_ev), 32'(4));
      chk("t6_pos_events2", 32'(pos_ev), 32'(10));
      for (int i = 0; i < 5; i++) begin
         cur = gray_step(cur, 1'b1);
         sb.push_back(cur);
      end
      for (int i = 0; i < 5; i++) send(1'b1);
      repeat (40) tick();
      chk("t6_pre_reset", 32'({a, b, pending}), 32'({2'b01, 4'h4}));
      do_reset();
      repeat (100) tick();
      chk("t6_post_reset", 32'({a, b, busy, pending, step_ready}), 32'(8'b0000_0001));
      chk("t6_no_edges", 32'(edge_cyc.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
